// File: rtl/c_hazard_ctrl_pkg.sv
// c_hazard_ctrl_pkg
// Shared definitions for the hazard controller: register-number sentinels,
// forwarding-select codes, the Tuse carried by operands that are not read,
// the per-stage hazard record and the destination-match helper.
package c_hazard_ctrl_pkg;

   localparam logic [31:0] NO_READ     = 32'hFFFF_FFFF;  // source operand not read
   localparam logic [31:0] NO_WRITE    = 32'hFFFF_FFFE;  // instruction writes no register
   localparam logic [31:0] TUSE_UNUSED = 32'd4;          // Tuse for an operand that is not read

   localparam logic [1:0] FWD_GRF = 2'd0;
   localparam logic [1:0] FWD_E   = 2'd1;
   localparam logic [1:0] FWD_M   = 2'd2;
   localparam logic [1:0] FWD_W   = 2'd3;

   // Destination register and remaining Tnew of one pipeline hazard register.
   typedef struct packed {
      logic [31:0] a3;
      logic [31:0] tnew;
   } hz_stage_t;

   // A source matches a destination only for a real register 1..31; this
   // rejects $0 and both sentinels with one range test.
   function automatic logic reg_match(input logic [31:0] src, input logic [31:0] a3);
      return (src == a3) && (a3 != 32'd0) && (a3 < 32'd32);
   endfunction

endpackage

// File: rtl/c_hazard_fwd_sel.sv
// c_hazard_fwd_sel
// Forwarding select for one source operand. The first stage (E, M, W order)
// whose destination matches the source decides: it is selected when its Tnew
// is 0, otherwise the GRF code is returned and the stall logic covers it.
// Parameter USE_E = 0 removes the E stage from the search (E-stage operands).
// Ports:
//   src    in   source register number
//   e_stg  in   E hazard record (a3, tnew)
//   m_stg  in   M hazard record
//   w_stg  in   W hazard record
//   hit_e  out  source matches the E destination (gated by USE_E)
//   hit_m  out  source matches the M destination
//   sel    out  FWD_GRF / FWD_E / FWD_M / FWD_W
module c_hazard_fwd_sel
   import c_hazard_ctrl_pkg::*;
#(
   parameter bit USE_E = 1'b1
) (
   input  logic [31:0] src,
   input  hz_stage_t   e_stg,
   input  hz_stage_t   m_stg,
   input  hz_stage_t   w_stg,
   output logic        hit_e,
   output logic        hit_m,
   output logic [1:0]  sel
);

   logic hit_w;

   assign hit_e = USE_E && reg_match(src, e_stg.a3);
   assign hit_m = reg_match(src, m_stg.a3);
   assign hit_w = reg_match(src, w_stg.a3);

   // A younger producer shadows older ones even when it is not ready yet.
   always_comb begin
      sel = FWD_GRF;
      if (hit_e)      sel = (e_stg.tnew == 32'd0) ? FWD_E : FWD_GRF;
      else if (hit_m) sel = (m_stg.tnew == 32'd0) ? FWD_M : FWD_GRF;
      else if (hit_w) sel = (w_stg.tnew == 32'd0) ? FWD_W : FWD_GRF;
   end

endmodule

// File: rtl/c_hazard_ctrl.sv
// c_hazard_ctrl
// Central hazard controller for the five-stage pipeline: data stall from
// Tuse/Tnew comparison, D- and E-stage forwarding selects, and (optionally)
// the multiply/divide busy counter.
// Build option: define HAZARD_MDU_EN to include the MDU counter, mdu_busy and
// the MDU stall term; otherwise mdu_busy is 0 and the MDU inputs are ignored.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   d_tuse_a1/a2, d_a1/a2      D-stage Tuse and source registers
//   e/m/w_tnew, e/m/w_a3       hazard-register Tnew and destinations
//   e_a1/a2                    E-stage source registers
//   d_uses_mdu                 D instruction touches the MDU / HI / LO
//   e_mdu_start, e_mdu_is_div  E instruction starts a mult (0) or div (1)
//   stall, d2e_setNOP          freeze PC/F2D, bubble into D2E
//   fwd_d_a1/a2, fwd_e_a1/a2   forwarding selects
//   mdu_busy                   MDU result not yet available
module c_hazard_ctrl
   import c_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_tuse_a1,
   input  logic [31:0] d_tuse_a2,
   input  logic [31:0] d_a1,
   input  logic [31:0] d_a2,
   input  logic [31:0] e_tnew,
   input  logic [31:0] m_tnew,
   input  logic [31:0] w_tnew,
   input  logic [31:0] e_a1,
   input  logic [31:0] e_a2,
   input  logic [31:0] e_a3,
   input  logic [31:0] m_a3,
   input  logic [31:0] w_a3,
   input  logic        d_uses_mdu,
   input  logic        e_mdu_start,
   input  logic        e_mdu_is_div,
   output logic        stall,
   output logic        d2e_setNOP,
   output logic [1:0]  fwd_d_a1,
   output logic [1:0]  fwd_d_a2,
   output logic [1:0]  fwd_e_a1,
   output logic [1:0]  fwd_e_a2,
   output logic        mdu_busy
);

   hz_stage_t e_stg, m_stg, w_stg, no_stg;

   assign e_stg.a3    = e_a3;
   assign e_stg.tnew  = e_tnew;
   assign m_stg.a3    = m_a3;
   assign m_stg.tnew  = m_tnew;
   assign w_stg.a3    = w_a3;
   assign w_stg.tnew  = w_tnew;
   assign no_stg.a3   = NO_WRITE;
   assign no_stg.tnew = 32'd0;

   // Operand slots: 0 = D a1, 1 = D a2, 2 = E a1, 3 = E a2.
   logic [3:0][31:0] srcs;
   logic [3:0][1:0]  sels;
   logic [3:0]       hit_e, hit_m;

   assign srcs = {e_a2, e_a1, d_a2, d_a1};

   // E-stage operands cannot forward from their own stage, so the E record
   // is replaced by a never-matching one for slots 2 and 3.
   for (genvar g = 0; g < 4; g++) begin : g_fwd
      c_hazard_fwd_sel #(.USE_E(g < 2)) u_sel (
         .src   (srcs[g]),
         .e_stg ((g < 2) ? e_stg : no_stg),
         .m_stg (m_stg),
         .w_stg (w_stg),
         .hit_e (hit_e[g]),
         .hit_m (hit_m[g]),
         .sel   (sels[g])
      );
   end

   assign fwd_d_a1 = sels[0];
   assign fwd_d_a2 = sels[1];
   assign fwd_e_a1 = sels[2];
   assign fwd_e_a2 = sels[3];

   // Only the D-stage operands stall; the E-stage match flags are not needed.
   logic [3:0] unused_e_hits;
   assign unused_e_hits = {hit_e[3:2], hit_m[3:2]};

   // Stall when the operand is needed before its producer can supply it.
   // W is omitted: anything in W is always ready to forward.
   logic data_stall;
   assign data_stall = (hit_e[0] && (d_tuse_a1 < e_tnew)) ||
                       (hit_m[0] && (d_tuse_a1 < m_tnew)) ||
                       (hit_e[1] && (d_tuse_a2 < e_tnew)) ||
                       (hit_m[1] && (d_tuse_a2 < m_tnew));

   logic mdu_stall;

`ifdef HAZARD_MDU_EN
   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

   logic [CNT_W-1:0] cnt;

   // A start while already counting is dropped; the MDU stall keeps legal
   // code from issuing one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (e_mdu_start && (cnt == '0))
         cnt <= e_mdu_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   // The start cycle counts as busy so a dependent instruction right behind
   // the mult/div stalls before cnt has loaded.
   assign mdu_busy  = (cnt != '0) | e_mdu_start;
   assign mdu_stall = d_uses_mdu & mdu_busy;
`else
   logic unused_mdu;
   assign unused_mdu = ^{clk, reset, d_uses_mdu, e_mdu_start, e_mdu_is_div};
   assign mdu_busy   = 1'b0;
   assign mdu_stall  = 1'b0;
`endif

   assign stall      = data_stall | mdu_stall;
   assign d2e_setNOP = stall;

endmodule
